// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller for a pair of A/B shift registers: drives shift_control
// for WIDTH clocks, returns sum bits on sum_ser and captures sum/cout. Optional macro: SERADD_SUBTRACT_EN.
module serial_adder_ctrl #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic             a_ser,
  input  logic             b_ser,
  input  logic             sub,
  output logic             shift_control,
  output logic             sum_ser,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             carry;
  logic             b_eff;
  logic             init_carry;
  logic             carry_nxt;

`ifdef SERADD_SUBTRACT_EN
  logic sub_l;

  // Subtract mode is frozen at the start edge so sub may change freely mid-operation.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      sub_l <= 1'b0;
    else if (state == IDLE && start)
      sub_l <= sub;
  end

  assign b_eff      = b_ser ^ sub_l;
  assign init_carry = sub;
`else
  logic unused_sub;

  assign unused_sub = sub;
  assign b_eff      = b_ser;
  assign init_carry = 1'b0;
`endif

  assign sum_ser   = a_ser ^ b_eff ^ carry;
  assign carry_nxt = (a_ser & b_eff) | (a_ser & carry) | (b_eff & carry);

  // NOTE: sequential state uses non-blocking assignments only, and the async reset
  // clears the registered outputs too so they drop in the same delta as rstn.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state         <= IDLE;
      cnt           <= '0;
      carry         <= 1'b0;
      sum           <= '0;
      cout          <= 1'b0;
      shift_control <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state         <= SHIFT;
            cnt           <= '0;
            carry         <= init_carry;
            sum           <= '0;
            shift_control <= 1'b1;
            busy          <= 1'b1;
          end
        end
        SHIFT: begin
          carry <= carry_nxt;
          sum   <= {sum_ser, sum[WIDTH-1:1]};
          cnt   <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(WIDTH - 1)) begin
            cout          <= carry_nxt;
            state         <= DONE;
            shift_control <= 1'b0;
            done          <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state         <= IDLE;
          shift_control <= 1'b0;
          busy          <= 1'b0;
          done          <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl: models the upstream A/B register pair, predicts
// each operation arithmetically and checks timing, serial bits and results.
module tb_serial_adder_ctrl;
  localparam int W  = 4;
  localparam int CW = 3;

  typedef struct {
    logic [W-1:0] s;
    logic         c;
  } exp_t;

  logic         clk = 1'b0;
  logic         rstn = 1'b1;
  logic         start = 1'b0;
  logic         sub = 1'b0;
  logic         a_ser, b_ser;
  logic         shift_control, sum_ser, cout, busy, done;
  logic [W-1:0] sum;

  logic [W-1:0] a_reg = '0, b_reg = '0, ld_a = '0, ld_b = '0;
  logic         ld = 1'b0;
  logic         mon_en = 1'b0;

  int   total = 0;
  int   bad = 0;
  int   phase = 0;
  exp_t exp_q[$];

  serial_adder_ctrl #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .rstn(rstn), .start(start), .a_ser(a_ser), .b_ser(b_ser), .sub(sub),
    .shift_control(shift_control), .sum_ser(sum_ser), .sum(sum), .cout(cout),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  assign a_ser = a_reg[0];
  assign b_ser = b_reg[0];

  // Upstream register pair: A takes sum_ser as its rotate input, B rotates onto itself.
  always @(posedge clk) begin
    if (ld) begin
      a_reg <= ld_a;
      b_reg <= ld_b;
    end else if (shift_control) begin
      a_reg <= {sum_ser, a_reg[W-1:1]};
      b_reg <= {b_reg[0], b_reg[W-1:1]};
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t ref_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    int unsigned bv;
    int unsigned t;
    exp_t r;
    bv  = s ? (~int'(b) & ((1 << W) - 1)) : int'(b);
    t   = int'(a) + bv + (s ? 1 : 0);
    r.s = t[W-1:0];
    r.c = t[W];
    return r;
  endfunction

  // Reference timing: phase counts clocks since an accepted start (1..W shift, W+1 done).
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      phase = 0;
      exp_q.delete();
    end else if (phase == 0) begin
      if (start) begin
`ifdef SERADD_SUBTRACT_EN
        exp_q.push_back(ref_op(a_reg, b_reg, sub));
`else
        exp_q.push_back(ref_op(a_reg, b_reg, 1'b0));
`endif
        phase = 1;
      end
    end else if (phase == W + 1) begin
      phase = 0;
    end else begin
      phase++;
    end
  end

  // Monitor: per-cycle control checks, serial bit checks and result pop on done.
  always @(negedge clk) begin
    if (mon_en) begin
      check("shift_control", 32'(shift_control), 32'(phase >= 1 && phase <= W));
      check("busy", 32'(busy), 32'(phase != 0));
      check("done", 32'(done), 32'(phase == W + 1));
      if (shift_control && exp_q.size() > 0 && phase >= 1 && phase <= W)
        check("sum_ser", 32'(sum_ser), 32'(exp_q[0].s[phase-1]));
      if (done) begin
        check("result_pending", 32'(exp_q.size()), 32'd1);
        if (exp_q.size() > 0) begin
          exp_t e;
          e = exp_q.pop_front();
          check("sum", 32'(sum), 32'(e.s));
          check("cout", 32'(cout), 32'(e.c));
          check("a_after", 32'(a_reg), 32'(e.s));
        end
      end
    end
  end

  task automatic load(input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    ld   = 1'b1;
    ld_a = a;
    ld_b = b;
    @(negedge clk);
    ld = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL done_timeout: got no done within %0d cycles at %0t", n, $time);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      total++;
      bad++;
      $display("FAIL idle_timeout: busy still high after %0d cycles at %0t", n, $time);
    end
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    load(a, b);
    @(negedge clk);
    start = 1'b1;
    sub   = s;
    @(negedge clk);
    start = 1'b0;
    sub   = 1'($urandom_range(0, 1));
    wait_done();
    @(negedge clk);
  endtask

  initial begin
    #1 rstn = 1'b0;
    #1 mon_en = 1'b1;
    check("rst_shift_control", 32'(shift_control), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;

    run_op(4'b1011, 4'b0010, 1'b0);
    run_op(4'b1111, 4'b0001, 1'b0);

    // Held start: back-to-back operations on evolving register contents.
    load(4'b0011, 4'b0011);
    @(negedge clk);
    start = 1'b1;
    repeat (20) @(negedge clk);
    start = 1'b0;
    wait_idle();
    @(negedge clk);

    // Asynchronous reset after the second shift cycle.
    load(4'b1010, 4'b0110);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rstn = 1'b0;
    #1;
    check("arst_shift_control", 32'(shift_control), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_sum", 32'(sum), 32'd0);
    check("arst_cout", 32'(cout), 32'd0);
    #1 rstn = 1'b1;
    @(negedge clk);
    run_op(4'b0101, 4'b0001, 1'b0);

    // start pulses while busy must be ignored.
    load(4'b0110, 4'b0111);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1;
    repeat (2) @(negedge clk);
    start = 1'b0;
    wait_done();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);

`ifdef SERADD_SUBTRACT_EN
    run_op(4'b1011, 4'b0010, 1'b1);
    run_op(4'b0010, 4'b1011, 1'b1);
`endif

    for (int i = 0; i < 12; i++)
      run_op(W'($urandom_range(0, (1 << W) - 1)), W'($urandom_range(0, (1 << W) - 1)),
             1'($urandom_range(0, 1)));

    repeat (3) @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
